// File: rtl/board_uart_tx_pkg.sv
// Shared sudoku board-link definitions: frame layout constants, serialiser
// state encoding and the per-cell byte packing.
package board_uart_tx_pkg;

   localparam int         FRAME_LEN     = 85;
   localparam logic [6:0] LAST_BYTE_IDX = 7'(FRAME_LEN - 1);
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START_BIT = 2'd1,
      ST_DATA      = 2'd2,
      ST_STOP      = 2'd3
   } tx_state_t;

   function automatic logic [7:0] cell_byte(input logic [1:0] vis, input logic [3:0] digit);
      return {2'b00, vis, digit};
   endfunction

endpackage

// File: rtl/board_uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser for one byte. A load on the final stop-bit
// cycle chains straight into the next start bit with no idle gap.
module uart_tx_byte
   import board_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       byte_done
);

   localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   tx_state_t         r_state, w_state_d;
   logic [BAUD_W-1:0] r_baud, w_baud_d;
   logic [2:0]        r_bit, w_bit_d;
   logic [7:0]        r_shift, w_shift_d;
   logic              r_tx, w_tx_d;
   logic              w_bit_end;

   assign w_bit_end = (r_baud == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_d;
         r_baud  <= w_baud_d;
         r_bit   <= w_bit_d;
         r_tx    <= w_tx_d;
      end
   end

   always_ff @(posedge clk) begin
      r_shift <= w_shift_d;
   end

   always_comb begin
      w_state_d = r_state;
      w_shift_d = r_shift;
      w_bit_d   = r_bit;
      w_baud_d  = w_bit_end ? '0 : r_baud + 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_baud_d = '0;
            w_bit_d  = '0;
            if (load) begin
               w_state_d = ST_START_BIT;
               w_shift_d = data;
            end
         end
         ST_START_BIT: begin
            if (w_bit_end) w_state_d = ST_DATA;
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_shift_d = {1'b0, r_shift[7:1]};
               w_bit_d   = r_bit + 3'd1;
               if (r_bit == 3'd7) w_state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_bit_end) begin
               if (load) begin
                  w_state_d = ST_START_BIT;
                  w_shift_d = data;
               end else begin
                  w_state_d = ST_IDLE;
               end
            end
         end
         default: w_state_d = ST_IDLE;
      endcase
   end

   // tx is registered from the next state so the line never glitches
   always_comb begin
      w_tx_d = 1'b1;
      case (w_state_d)
         ST_START_BIT: w_tx_d = 1'b0;
         ST_DATA:      w_tx_d = w_shift_d[0];
         default:      w_tx_d = 1'b1;
      endcase
      byte_done = (r_state == ST_STOP) && w_bit_end;
   end

   assign tx = r_tx;

endmodule

// File: rtl/board_uart_tx.sv
// Streams a snapshot of the sudoku board state as one 85-byte UART frame:
// sync, 81 cells, cursor, strikes, XOR checksum.
module board_uart_tx
   import board_uart_tx_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [323:0] board,
   input  logic [161:0] visibilities,
   input  logic [7:0]   position,
   input  logic [1:0]   strikes,
   output logic         tx,
   output logic         busy,
   output logic         done
);

   logic [323:0] r_board;
   logic [161:0] r_vis;
   logic [7:0]   r_pos;
   logic [1:0]   r_strikes;
   logic [7:0]   r_csum;
   logic [6:0]   r_idx;
   logic         r_busy, r_done;

   logic       w_accept, w_byte_done, w_last, w_load;
   logic [6:0] w_load_idx;
   logic [7:0] w_byte;

   assign w_accept   = start & ~r_busy;
   assign w_last     = (r_idx == LAST_BYTE_IDX);
   assign w_load     = w_accept | (w_byte_done & ~w_last);
   assign w_load_idx = w_accept ? 7'd0 : r_idx + 7'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_idx  <= '0;
      end else begin
         r_done <= w_byte_done & w_last;
         if (w_accept) begin
            r_busy <= 1'b1;
            r_idx  <= '0;
         end else if (w_byte_done) begin
            if (w_last) begin
               r_busy <= 1'b0;
               r_idx  <= '0;
            end else begin
               r_idx <= r_idx + 7'd1;
            end
         end
      end
   end

   // Checksum accumulates bytes 1..83 as they are handed to the serialiser
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_board   <= board;
         r_vis     <= visibilities;
         r_pos     <= position;
         r_strikes <= strikes;
         r_csum    <= '0;
      end else if (w_byte_done && !w_last && (w_load_idx != LAST_BYTE_IDX)) begin
         r_csum <= r_csum ^ w_byte;
      end
   end

   always_comb begin
      w_byte = r_csum;
      if (w_load_idx == 7'd0) begin
         w_byte = SYNC_BYTE;
      end else if (w_load_idx <= 7'd81) begin
         for (int k = 0; k < 81; k++) begin
            if (w_load_idx == 7'(k + 1)) w_byte = cell_byte(r_vis[2*k +: 2], r_board[4*k +: 4]);
         end
      end else if (w_load_idx == 7'd82) begin
         w_byte = r_pos;
      end else if (w_load_idx == 7'd83) begin
         w_byte = {6'b0, r_strikes};
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .clk      (clk),
      .reset    (reset),
      .load     (w_load),
      .data     (w_byte),
      .tx       (tx),
      .byte_done(w_byte_done)
   );

   assign busy = r_busy;
   assign done = r_done;

endmodule
